// File: rtl/div_seq_restoring_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t    : FSM encoding (IDLE / RUN / DONE)
//   cnt_width  : iteration-counter width for a given operand width, clog2(N)
//   CNT_W      : counter width at the default operand width
//   ERR_QUOT   : all-ones quotient reported on divide-by-zero / overflow;
//                sliced to N bits by the user
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter runs N-1 down to 0, so clog2(N) bits suffice; keep at least 1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int N_DEF = 32;
    localparam int CNT_W = cnt_width(N_DEF);

    localparam logic [127:0] ERR_QUOT = '1;

endpackage

// File: rtl/div_seq_restoring_if.sv
// Request/response bundle of the divider.
//   en, start, dividend[2N], divisor[N]            : master -> divider
//   busy, done, quotient[N], remainder[N],
//   div_by_zero, overflow                          : divider -> master
interface div_seq_restoring_if #(parameter int N = 32);

    logic             en;
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output en, start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  en, start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_seq_restoring_step.sv
// One restoring-division iteration, purely combinational.
//   rq      [2N+1] : {R (N+1 bits), Q (N bits)} before the iteration
//   divisor [N]    : divisor
//   rq_next [2N+1] : {R, Q} after shift / trial subtract / restore
module div_step #(
    parameter int N = 32
) (
    input  logic [2*N:0]  rq,
    input  logic [N-1:0]  divisor,
    output logic [2*N:0]  rq_next
);

    logic [2*N:0] shifted;
    logic [N:0]   trial;

    // R < divisor holds between iterations, so rq[2N] is always 0 and the
    // shifted remainder still fits in N+1 bits.
    assign shifted = {rq[2*N-1:0], 1'b0};
    assign trial   = shifted[2*N:N] - {1'b0, divisor};

    // Trial MSB set means the subtraction went negative: keep the shifted R.
    assign rq_next = trial[N] ? shifted : {trial, shifted[N-1:1], 1'b1};

endmodule

// File: rtl/div_seq_restoring.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor ->
// N-bit quotient and remainder after N iteration cycles.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of div_seq_restoring_if (en/start/operands in,
//           busy/done/results/flags out)
// Divide-by-zero and quotient overflow are detected at accept time and go
// straight to DONE with the all-ones quotient.
module div_seq_restoring
    import div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    div_seq_restoring_if.slave     bus
);

    localparam int CW = cnt_width(N);

    state_t          state, nstate;
    logic [N:0]      r;
    logic [N-1:0]    q;
    logic [N-1:0]    dvs;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    quot, rem;
    logic            dbz, ovf;
    logic [2*N:0]    rq_next;

    logic [N-1:0]    hi, lo;
    logic            is_zero, is_ovf;

    assign hi      = bus.dividend[2*N-1:N];
    assign lo      = bus.dividend[N-1:0];
    assign is_zero = (bus.divisor == '0);
    assign is_ovf  = (hi >= bus.divisor);

    div_step #(.N(N)) u_step (
        .rq      ({r, q}),
        .divisor (dvs),
        .rq_next (rq_next)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic; en=0 freezes everything, including DONE.
    always_comb begin
        nstate = state;
        if (bus.en) begin
            case (state)
                IDLE: if (bus.start) nstate = (is_zero || is_ovf) ? DONE : RUN;
                RUN:  if (cnt == '0) nstate = DONE;
                DONE: nstate = IDLE;
                default: nstate = IDLE;
            endcase
        end
    end

    // Outputs come from registers only.
    always_comb begin
        bus.busy        = (state == RUN);
        bus.done        = (state == DONE);
        bus.quotient    = quot;
        bus.remainder   = rem;
        bus.div_by_zero = dbz;
        bus.overflow    = ovf;
    end

    // Datapath: operand latch, iteration registers and result registers.
    // Results are written on the edge that enters DONE so they are visible
    // together with done; on a normal accept only the flags clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r    <= '0;
            q    <= '0;
            dvs  <= '0;
            cnt  <= '0;
            quot <= '0;
            rem  <= '0;
            dbz  <= 1'b0;
            ovf  <= 1'b0;
        end else if (bus.en) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvs <= bus.divisor;
                        if (is_zero) begin
                            dbz  <= 1'b1;
                            ovf  <= 1'b0;
                            quot <= ERR_QUOT[N-1:0];
                            rem  <= lo;
                        end else if (is_ovf) begin
                            dbz  <= 1'b0;
                            ovf  <= 1'b1;
                            quot <= ERR_QUOT[N-1:0];
                            rem  <= '0;
                        end else begin
                            dbz <= 1'b0;
                            ovf <= 1'b0;
                            r   <= {1'b0, hi};
                            q   <= lo;
                            cnt <= CW'(N - 1);
                        end
                    end
                end
                RUN: begin
                    r <= rq_next[2*N:N];
                    q <= rq_next[N-1:0];
                    if (cnt == '0) begin
                        quot <= rq_next[N-1:0];
                        rem  <= rq_next[2*N-1:N];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_seq_restoring.md
# div_seq_restoring

Sequential unsigned restoring divider. It is the inverse of the team's registered X multiplier: it accepts a 2N-bit dividend (the multiplier's product width) and an N-bit divisor, and produces an N-bit quotient and an N-bit remainder after N iteration cycles. It sits beside the multiplier in the arithmetic datapath and uses a start/done handshake instead of a fixed pipeline.

## Interface
- N, default 32, operand width; the dividend is 2N bits and the quotient and remainder are N bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  clock enable; when 0, all state, outputs and handshake acceptance are frozen.
- start  input  1  request; sampled only in IDLE with en=1.
- dividend  input  2N  unsigned dividend; sampled with start.
- divisor  input  N  unsigned divisor; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on entry to DONE.
- quotient  output  N  result; held until the next accepted start.
- remainder  output  N  result; held until the next accepted start.
- div_by_zero  output  1  the last accepted request had divisor == 0.
- overflow  output  1  the last accepted request had dividend[2N-1:N] >= divisor and divisor != 0.

## Operation
- **Reset.** Asserting reset (0) forces the following, regardless of en or clock, including mid-operation:
  - state = IDLE;
  - busy, done, div_by_zero and overflow = 0;
  - quotient and remainder = 0;
  - iteration counter = 0.
- **States.** IDLE, RUN and DONE.
- **IDLE, start=1 and en=1:**
  - latch the operands;
  - if divisor == 0: set div_by_zero=1, quotient = all ones, remainder = dividend[N-1:0], go to DONE;
  - else if dividend[2N-1:N] >= divisor: set overflow=1, quotient = all ones, remainder = 0, go to DONE;
  - else: load R (N+1 bits) = {0, dividend[2N-1:N]}, load Q = dividend[N-1:0], set counter = N-1, clear both flags, go to RUN.
- **RUN, per cycle with en=1:**
  - shift {R,Q} left by 1; Q[0] takes 0;
  - form trial = R - {0,divisor} at N+1 bits;
  - if trial is non-negative (MSB = 0), set R = trial and Q[0] = 1;
  - if counter == 0, go to DONE; else decrement counter.
- **DONE (one cycle):**
  - done = 1;
  - quotient = Q and remainder = R[N-1:0] (or the error values above);
  - go to IDLE unconditionally.
- **start handling:**
  - start while busy or in DONE is ignored and not queued;
  - start in the DONE cycle is ignored;
  - a start on the first IDLE cycle after DONE is accepted.
- **Result validity.** Results are valid from the done cycle until the cycle after the next accepted start. At that point quotient and remainder keep their old values until the next DONE; only the flags clear.
- **en=0** inserts stall cycles anywhere, including holding done high. done stays asserted until en returns and DONE advances.

## Timing
- Normal request, latency from start edge to done: N+1 enabled cycles (1 load, N iterations; done is asserted in the cycle after the last iteration).
- Divide-by-zero or overflow: done in the first enabled cycle after start, a latency of 1.
- Throughput: one request per N+2 cycles, because the DONE cycle leaves 1 idle cycle.
- busy = 1 for exactly N enabled cycles per normal request.
- The operands may change freely after the start cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package div_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - the counter-width localparam, computed as clog2(N);
  - the error quotient constant (all ones).
- One natural sub-module, div_step: a combinational single restoring iteration. It takes {R,Q} and divisor and returns the next {R,Q}.
- The top-level holds the FSM, counter and registers.

## Test plan
- N=32, dividend=100, divisor=7, start pulse → done after 33 cycles, quotient=14, remainder=2, both flags 0, busy high for 32 cycles.
- dividend=0x0000_0001_0000_0000, divisor=3 → quotient=0x5555_5555, remainder=1.
- divisor=0, dividend=0x1234 → done 1 cycle after start, div_by_zero=1, quotient=0xFFFF_FFFF, remainder=0x1234.
- dividend=0x0000_0005_0000_0000, divisor=5 → overflow=1, quotient=0xFFFF_FFFF, remainder=0, done after 1 cycle.
- start re-pulsed during RUN with different operands → ignored, and the original result completes.
  - Then hold en=0 for 5 cycles mid-RUN → done arrives exactly 5 cycles later with unchanged result.
- reset asserted (0) at iteration 10 → all outputs 0 immediately.
  - A new start after release yields the correct result with full N+1 latency.
- Random regression (N=8 and N=32, 10k vectors with dividend high half < divisor): check quotient*divisor + remainder == dividend and remainder < divisor.
